// File: rtl/food_map_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// food_map_access_ctrl_if
// Purpose : bundles the requester handshakes (pacman eat, display read), the
//           single-port food_map BRAM bus and the food-count status of
//           food_map_access_ctrl into one interface.
// Signals :
//   eat_req/eat_row/eat_col    eat request (level) and tile coordinates
//   eat_ack/eat_hit            eat completion pulse and "food was cleared"
//   disp_req/disp_row          display row read request (level) and row
//   disp_ack/disp_data         display completion pulse and row contents
//   bram_en/we/addr/din/dout   food_map BRAM port
//   food_left/all_eaten        remaining food count and game-over flag
// Modports: slave  = the controller
//           master = the surroundings (requesters plus the BRAM instance)
// ---------------------------------------------------------------------------
interface food_map_access_ctrl_if #(
  parameter int ROW_W  = 80,
  parameter int ADDR_W = 6,
  parameter int COL_W  = 7,
  parameter int CNT_W  = 12
);
  logic              eat_req;
  logic [ADDR_W-1:0] eat_row;
  logic [COL_W-1:0]  eat_col;
  logic              eat_ack;
  logic              eat_hit;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_row;
  logic              disp_ack;
  logic [ROW_W-1:0]  disp_data;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [ROW_W-1:0]  bram_din;
  logic [ROW_W-1:0]  bram_dout;
  logic [CNT_W-1:0]  food_left;
  logic              all_eaten;

  modport slave (
    input  eat_req, eat_row, eat_col, disp_req, disp_row, bram_dout,
    output eat_ack, eat_hit, disp_ack, disp_data,
           bram_en, bram_we, bram_addr, bram_din, food_left, all_eaten
  );

  modport master (
    output eat_req, eat_row, eat_col, disp_req, disp_row, bram_dout,
    input  eat_ack, eat_hit, disp_ack, disp_data,
           bram_en, bram_we, bram_addr, bram_din, food_left, all_eaten
  );
endinterface

// File: rtl/food_map_access_ctrl.sv
// ---------------------------------------------------------------------------
// food_map_access_ctrl
// Purpose : sequences the single-port food_map BRAM (one row per maze line,
//           one bit per tile) between two requesters: pacman eat requests
//           (read-modify-write clearing a food bit) and display row reads.
//           Round-robin arbitration on ties, display wins the first tie.
//           Tracks the remaining food count and raises all_eaten at zero.
// Ports   :
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  food_map_access_ctrl_if.slave (requests, acks, BRAM port, status)
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module food_map_access_ctrl #(
  parameter int ROW_W     = 80,
  parameter int ADDR_W    = 6,
  parameter int COL_W     = 7,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 12,
  parameter int INIT_FOOD = 1200
) (
  input logic                   clk,
  input logic                   rst,
  food_map_access_ctrl_if.slave bus
);

  localparam int                WCNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [COL_W:0]    COL_LIM   = (COL_W+1)'(ROW_W);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  FOOD_INIT = CNT_W'(INIT_FOOD);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_DISP_ACK, S_EAT_WR, S_EAT_NOP
  } state_t;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  function automatic logic [ROW_W-1:0] clr_bit(input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col);
    logic [ROW_W-1:0] r;
    r      = row;
    r[col] = 1'b0;
    return r;
  endfunction

  // control state
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_eat;   // 1: last grant went to eat
  logic              r_is_eat;     // type of the transaction in flight
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [COL_W-1:0]  r_col;

  // registered outputs
  logic              r_eat_ack, r_eat_hit, r_disp_ack;
  logic [ROW_W-1:0]  r_disp_data;
  logic              r_en, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [ROW_W-1:0]  r_din;
  logic [CNT_W-1:0]  r_food;
  logic              r_all_eaten;

  // arbitration
  logic              w_grant, w_grant_eat;
  logic [ADDR_W-1:0] w_grant_row;
  logic              w_col_oor;

  // next output values
  logic              w_eat_ack_nxt, w_eat_hit_nxt, w_disp_ack_nxt;
  logic [ROW_W-1:0]  w_disp_data_nxt;
  logic              w_en_nxt, w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ROW_W-1:0]  w_din_nxt;
  logic [CNT_W-1:0]  w_food_nxt;
  logic              w_hit;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_eat  <= 1'b1;
      r_is_eat    <= 1'b0;
      r_wait_cnt  <= '0;
      r_eat_ack   <= 1'b0;
      r_eat_hit   <= 1'b0;
      r_disp_ack  <= 1'b0;
      r_disp_data <= '0;
      r_en        <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_food      <= FOOD_INIT;
      r_all_eaten <= (INIT_FOOD == 0);
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last_eat <= w_grant_eat;
        r_is_eat   <= w_grant_eat;
      end
      if (r_state == S_RD)
        r_wait_cnt <= WAIT_LOAD;
      else if (r_wait_cnt != '0)
        r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
      r_eat_ack   <= w_eat_ack_nxt;
      r_eat_hit   <= w_eat_hit_nxt;
      r_disp_ack  <= w_disp_ack_nxt;
      r_disp_data <= w_disp_data_nxt;
      r_en        <= w_en_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
      r_food      <= w_food_nxt;
      r_all_eaten <= (w_food_nxt == '0);
    end
  end

  // Column latch: pure data, only meaningful after a grant
  always_ff @(posedge clk) begin
    if (w_grant) r_col <= bus.eat_col;
  end

  // Next-state logic and arbitration
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_eat = 1'b0;
    w_col_oor   = ({1'b0, bus.eat_col} >= COL_LIM);
    case (r_state)
      S_IDLE: begin
        if (bus.eat_req && bus.disp_req) begin
          w_grant     = 1'b1;
          w_grant_eat = ~r_last_eat;
        end else if (bus.eat_req) begin
          w_grant     = 1'b1;
          w_grant_eat = 1'b1;
        end else if (bus.disp_req) begin
          w_grant     = 1'b1;
        end
        // Off-map columns never touch the BRAM: acknowledge a miss directly
        if (w_grant)
          w_state_nxt = (w_grant_eat && w_col_oor) ? S_EAT_NOP : S_RD;
      end
      S_RD:    w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt == '0)
          w_state_nxt = r_is_eat ? S_EAT_WR : S_DISP_ACK;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_grant_row = w_grant_eat ? bus.eat_row : bus.disp_row;
  end

  // Output decode: values the registers take on entering w_state_nxt.
  // DISP_ACK / EAT_WR are entered only from the last WAIT cycle, where
  // bram_dout carries the requested row.
  always_comb begin
    w_eat_ack_nxt   = 1'b0;
    w_eat_hit_nxt   = 1'b0;
    w_disp_ack_nxt  = 1'b0;
    w_disp_data_nxt = r_disp_data;
    w_en_nxt        = 1'b0;
    w_we_nxt        = 1'b0;
    w_addr_nxt      = r_addr;
    w_din_nxt       = r_din;
    w_food_nxt      = r_food;
    w_hit           = bus.bram_dout[r_col];
    case (w_state_nxt)
      S_RD: begin
        w_en_nxt   = 1'b1;
        w_addr_nxt = w_grant_row;
      end
      S_WAIT: w_en_nxt = 1'b1;
      S_DISP_ACK: begin
        w_disp_ack_nxt  = 1'b1;
        w_disp_data_nxt = bus.bram_dout;
      end
      S_EAT_WR: begin
        w_eat_ack_nxt = 1'b1;
        w_eat_hit_nxt = w_hit;
        if (w_hit) begin
          w_en_nxt   = 1'b1;
          w_we_nxt   = 1'b1;
          w_din_nxt  = clr_bit(bus.bram_dout, r_col);
          w_food_nxt = sat_dec(r_food);
        end
      end
      S_EAT_NOP: w_eat_ack_nxt = 1'b1;
      default: ;
    endcase
  end

  assign bus.eat_ack   = r_eat_ack;
  assign bus.eat_hit   = r_eat_hit;
  assign bus.disp_ack  = r_disp_ack;
  assign bus.disp_data = r_disp_data;
  assign bus.bram_en   = r_en;
  assign bus.bram_we   = r_we;
  assign bus.bram_addr = r_addr;
  assign bus.bram_din  = r_din;
  assign bus.food_left = r_food;
  assign bus.all_eaten = r_all_eaten;

endmodule
